// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus: memory read port plus decoder valid/ready handshake.
// master = fetch unit, slave = memory/decoder side.
interface instr_fetch_unit_if;
  logic [63:0] instr_port;
  logic [7:0]  instr_fetch_addr;
  logic        instr_rd_en;
  logic [63:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    input  instr_port, instr_ready,
    output instr_fetch_addr, instr_rd_en, instr_out, instr_valid
  );

  modport slave (
    output instr_port, instr_ready,
    input  instr_fetch_addr, instr_rd_en, instr_out, instr_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction prefetch stage: sequential reads from START_ADDR into a small
// FIFO, handed to the decoder over valid/ready, stopping after an END word.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_count / stall_count.
module instr_fetch_unit #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter logic [3:0] END_OPCODE = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                acc_enable,
  input  logic                flush,
  instr_fetch_unit_if.master  bus,
  output logic                busy,
  output logic                done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         fetch_count,
  output logic [15:0]         stall_count
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    r_state;
  logic          r_acc_d;
  logic [7:0]    r_addr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [63:0]   r_mem [FIFO_DEPTH];
  logic          r_done;

  logic          w_start;
  logic          w_rd;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;
  logic          w_pop_ok;
  logic [63:0]   w_head;
  logic          w_end_in;
  logic          w_end_out;

  // Read only on the current count: a full FIFO issues no read even if it
  // pops this cycle, costing one bubble but keeping rd_en off the ready path.
  assign w_start   = (r_state == S_IDLE) & acc_enable & ~r_acc_d;
  assign w_rd      = (r_state == S_FETCH) & (r_count < DEPTH_C);
  assign w_push    = w_rd & ~flush;
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid & bus.instr_ready;
  assign w_pop_ok  = w_pop & ~flush;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_end_in  = (bus.instr_port[63:60] == END_OPCODE);
  assign w_end_out = (w_head[63:60] == END_OPCODE);

  assign bus.instr_rd_en      = w_rd;
  assign bus.instr_fetch_addr = r_addr;
  assign bus.instr_out        = w_head;
  assign bus.instr_valid      = w_valid;
  assign busy                 = (r_state != S_IDLE);
  assign done                 = r_done;

  // acc_enable history for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_acc_d <= 1'b0;
    else      r_acc_d <= acc_enable;
  end

  // Run control; flush beats everything, including a simultaneous start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) r_state <= S_FETCH;
        S_FETCH: if (w_push && w_end_in) r_state <= S_DRAIN;
        S_DRAIN: if (w_pop && w_end_out) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Fetch address: reload on start, step on every read, wraps at 8 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_addr <= 8'h00;
    else if (!flush && w_start)  r_addr <= START_ADDR;
    else if (w_push)             r_addr <= r_addr + 8'h01;
  end

  // FIFO occupancy and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so instr_out reads zero out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= bus.instr_port;
    end
  end

  // done pulses the cycle after the END word leaves the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done <= 1'b0;
    else      r_done <= w_pop_ok && (r_state == S_DRAIN) && w_end_out;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;

  // Saturating per-run counters, cleared on start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= 16'h0;
      r_stall_cnt <= 16'h0;
    end else if (!flush && w_start) begin
      r_fetch_cnt <= 16'h0;
      r_stall_cnt <= 16'h0;
    end else begin
      if (w_push && r_fetch_cnt != 16'hFFFF)
        r_fetch_cnt <= r_fetch_cnt + 16'h1;
      if (w_valid && !bus.instr_ready && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Expected streams come from a
// memory-walk model: words from the start address up to the first END opcode.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic acc, flush, busy, done;
  logic acc2, flush2, busy2, done2;
  logic [63:0] mem [256];

  always #5 clk = ~clk;

  instr_fetch_unit_if ifc  ();
  instr_fetch_unit_if ifc2 ();

  assign ifc.instr_port  = mem[ifc.instr_fetch_addr];
  assign ifc2.instr_port = mem[ifc2.instr_fetch_addr];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fc, sc, fc2, sc2;
`endif

  instr_fetch_unit #(.FIFO_DEPTH(4), .START_ADDR(8'h00), .END_OPCODE(4'hF)) u_dut (
    .clk(clk), .rst(rst), .acc_enable(acc), .flush(flush), .bus(ifc),
    .busy(busy), .done(done)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fc), .stall_count(sc)
`endif
  );

  instr_fetch_unit #(.FIFO_DEPTH(4), .START_ADDR(8'hFE), .END_OPCODE(4'hF)) u_dut_wrap (
    .clk(clk), .rst(rst), .acc_enable(acc2), .flush(flush2), .bus(ifc2),
    .busy(busy2), .done(done2)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fc2), .stall_count(sc2)
`endif
  );

  int total = 0;
  int bad   = 0;

  // bus monitors: addresses read, words popped, done pulses
  logic [7:0]  rd_a[$];
  logic [63:0] got[$];
  int          done_n = 0;
  logic [7:0]  rd_a2[$];
  logic [63:0] got2[$];
  int          done_n2 = 0;
  logic [63:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      if (ifc.instr_rd_en) rd_a.push_back(ifc.instr_fetch_addr);
      if (ifc.instr_valid && ifc.instr_ready) got.push_back(ifc.instr_out);
      if (done) done_n++;
      if (ifc2.instr_rd_en) rd_a2.push_back(ifc2.instr_fetch_addr);
      if (ifc2.instr_valid && ifc2.instr_ready) got2.push_back(ifc2.instr_out);
      if (done2) done_n2++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // program of n words at base; only the last one carries the END opcode
  task automatic load_prog(input logic [7:0] base, input int n);
    logic [63:0] w;
    logic [7:0]  a;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      w[63:60] = (i == n - 1) ? 4'hF : 4'($urandom_range(0, 14));
      a = base + 8'(i);
      mem[a] = w;
    end
  endtask

  // reference: walk memory from s until the first END word
  task automatic build_exp(input logic [7:0] s);
    logic [7:0] a;
    a = s;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(mem[a]);
      if (mem[a][63:60] == 4'hF) break;
      a = a + 8'h01;
    end
  endtask

  task automatic cmp_run(input string tag, input int g0, input int r0, input logic [7:0] s);
    logic [7:0] a;
    build_exp(s);
    chk({tag, ".npop"}, 64'(got.size() - g0), 64'(exp_q.size()));
    chk({tag, ".nrd"}, 64'(rd_a.size() - r0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      a = s + 8'(i);
      if (g0 + i < got.size()) chk({tag, ".word"}, got[g0 + i], exp_q[i]);
      if (r0 + i < rd_a.size()) chk({tag, ".addr"}, 64'(rd_a[r0 + i]), 64'(a));
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int i;
    i = 0;
    while (busy && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk({tag, ".timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".addr"},  64'(ifc.instr_fetch_addr), 64'h0);
    chk({tag, ".rd_en"}, 64'(ifc.instr_rd_en), 64'h0);
    chk({tag, ".out"},   ifc.instr_out, 64'h0);
    chk({tag, ".valid"}, 64'(ifc.instr_valid), 64'h0);
    chk({tag, ".busy"},  64'(busy), 64'h0);
    chk({tag, ".done"},  64'(done), 64'h0);
  endtask

  initial begin
    int g0, r0, d0, n;

    rst = 1'b0; acc = 1'b0; flush = 1'b0; acc2 = 1'b0; flush2 = 1'b0;
    ifc.instr_ready = 1'b0; ifc2.instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = {4'h0, 28'($urandom), 32'($urandom)};
    #12;
    chk_reset_vals("reset");
    chk("reset.busy2", 64'(busy2), 64'h0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // ---- basic 4-word run, opcodes 1,2,3,F, ready tied high
    load_prog(8'h00, 4);
    mem[0][63:60] = 4'h1; mem[1][63:60] = 4'h2; mem[2][63:60] = 4'h3;
    ifc.instr_ready = 1'b1;
    g0 = got.size(); r0 = rd_a.size(); d0 = done_n;
    acc = 1'b1;
    @(negedge clk);
    chk("t1.busy_N",  64'(busy), 64'h1);
    chk("t1.rd_en_N", 64'(ifc.instr_rd_en), 64'h1);
    chk("t1.addr_N",  64'(ifc.instr_fetch_addr), 64'h0);
    chk("t1.valid_N", 64'(ifc.instr_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1.valid_seq", 64'(ifc.instr_valid), 64'h1);
      chk("t1.out_seq", ifc.instr_out, mem[i]);
    end
    chk("t1.rd_en_after_end", 64'(ifc.instr_rd_en), 64'h0);
    @(negedge clk);
    chk("t1.done_pulse", 64'(done), 64'h1);
    chk("t1.busy_low", 64'(busy), 64'h0);
    @(negedge clk);
    chk("t1.done_once", 64'(done), 64'h0);
    acc = 1'b0;
    repeat (2) @(negedge clk);
    cmp_run("t1", g0, r0, 8'h00);
    chk("t1.ndone", 64'(done_n - d0), 64'd1);

    // ---- backpressure: 10-word program, ready low for 10 valid cycles
    load_prog(8'h00, 10);
    ifc.instr_ready = 1'b0;
    g0 = got.size(); r0 = rd_a.size(); d0 = done_n;
    acc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("t2.reads_full", 64'(rd_a.size() - r0), 64'd4);
    chk("t2.rd_en_full", 64'(ifc.instr_rd_en), 64'h0);
    chk("t2.head", ifc.instr_out, mem[0]);
    ifc.instr_ready = 1'b1;
    acc = 1'b0;
    wait_idle("t2", 200);
    repeat (2) @(negedge clk);
    cmp_run("t2", g0, r0, 8'h00);
    chk("t2.ndone", 64'(done_n - d0), 64'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("t2.stall_count", 64'(sc), 64'd10);
    chk("t2.fetch_count", 64'(fc), 64'd10);
`endif

    // ---- random ready pattern, 12-word program
    load_prog(8'h00, 12);
    g0 = got.size(); r0 = rd_a.size(); d0 = done_n;
    acc = 1'b1;
    @(negedge clk);
    acc = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      ifc.instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    ifc.instr_ready = 1'b1;
    chk("t3.timeout", 64'(busy), 64'h0);
    repeat (2) @(negedge clk);
    cmp_run("t3", g0, r0, 8'h00);
    chk("t3.ndone", 64'(done_n - d0), 64'd1);

    // ---- flush in the 3rd FETCH cycle, then restart
    load_prog(8'h00, 8);
    d0 = done_n;
    acc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; acc = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("t4.busy", 64'(busy), 64'h0);
    chk("t4.valid", 64'(ifc.instr_valid), 64'h0);
    chk("t4.rd_en", 64'(ifc.instr_rd_en), 64'h0);
    repeat (3) @(negedge clk);
    chk("t4.no_done", 64'(done_n - d0), 64'd0);
    g0 = got.size(); r0 = rd_a.size();
    acc = 1'b1;
    @(negedge clk);
    chk("t4.restart_addr", 64'(ifc.instr_fetch_addr), 64'h0);
    chk("t4.restart_rd", 64'(ifc.instr_rd_en), 64'h1);
    wait_idle("t4", 200);
    acc = 1'b0;
    repeat (2) @(negedge clk);
    cmp_run("t4", g0, r0, 8'h00);
    chk("t4.ndone", 64'(done_n - d0), 64'd1);

    // ---- retrigger while busy is ignored
    load_prog(8'h00, 10);
    ifc.instr_ready = 1'b0;
    g0 = got.size(); r0 = rd_a.size(); d0 = done_n;
    acc = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      acc = ~acc;
      @(negedge clk);
    end
    acc = 1'b0;
    ifc.instr_ready = 1'b1;
    wait_idle("t5", 200);
    repeat (2) @(negedge clk);
    cmp_run("t5", g0, r0, 8'h00);
    chk("t5.ndone", 64'(done_n - d0), 64'd1);

    // ---- async reset in DRAIN
    load_prog(8'h00, 3);
    ifc.instr_ready = 1'b0;
    d0 = done_n;
    acc = 1'b1;
    @(negedge clk);
    acc = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6.drain_busy", 64'(busy), 64'h1);
    chk("t6.drain_rd", 64'(ifc.instr_rd_en), 64'h0);
    chk("t6.drain_valid", 64'(ifc.instr_valid), 64'h1);
    #2 rst = 1'b0;
    #1 chk_reset_vals("t6.async");
    @(negedge clk);
    rst = 1'b1;
    ifc.instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6.idle_busy", 64'(busy), 64'h0);
    chk("t6.idle_valid", 64'(ifc.instr_valid), 64'h0);
    chk("t6.no_done", 64'(done_n - d0), 64'd0);

    // ---- address wrap on the FE-based instance
    load_prog(8'hFE, 4);
    g0 = got2.size(); r0 = rd_a2.size(); d0 = done_n2;
    acc2 = 1'b1;
    @(negedge clk);
    acc2 = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t7.timeout", 64'(busy2), 64'h0);
    repeat (2) @(negedge clk);
    build_exp(8'hFE);
    chk("t7.npop", 64'(got2.size() - g0), 64'd4);
    chk("t7.nrd", 64'(rd_a2.size() - r0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = 8'hFE + 8'(i);
      if (r0 + i < rd_a2.size()) chk("t7.addr", 64'(rd_a2[r0 + i]), 64'(a));
      if (g0 + i < got2.size() && i < exp_q.size()) chk("t7.word", got2[g0 + i], exp_q[i]);
    end
    chk("t7.ndone", 64'(done_n2 - d0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction prefetch stage between the external instruction memory port (`instr_port` / `instr_fetch_addr` / `instr_rd_en`) and the instruction decoder inside `top`. When a run starts, it reads 64-bit instruction words sequentially from a start address into a small prefetch FIFO. It hands the words to the decoder over a valid/ready handshake and stops after fetching an END instruction. It provides the decoupling that lets the decoder stall without losing memory reads.

## Interface
- `FIFO_DEPTH`, 4: prefetch FIFO entries; power of two, 2..16.
- `START_ADDR`, 8'h00: first instruction address fetched on each start.
- `END_OPCODE`, 4'hF: opcode value (`instr[63:60]`) that marks the last instruction.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `acc_enable`  in  1  run request; its rising edge starts a fetch run.
- `flush`  in  1  synchronous abort; empties the FIFO and returns to IDLE.
- `instr_port`  in  64  memory read data; combinational for the address currently driven.
- `instr_fetch_addr`  out  8  memory read address.
- `instr_rd_en`  out  1  memory read strobe; `instr_port` is captured at the edge ending each cycle in which this is high.
- `instr_out`  out  64  FIFO head word to the decoder.
- `instr_valid`  out  1  `instr_out` is valid (FIFO not empty).
- `instr_ready`  in  1  decoder accepts `instr_out`; pop happens when valid and ready are both high.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the END word has been popped.

## Operation
- States:
  - IDLE: `acc_enable` high and its registered previous value low → FETCH; the address register is loaded with `START_ADDR`.
  - FETCH: `instr_rd_en = (count < FIFO_DEPTH)`. On each read, the word is pushed and the address increments. If the pushed word has opcode `END_OPCODE` → DRAIN.
  - DRAIN: no reads. When the END word is popped → IDLE and `done` pulses.
- The push decision uses the current count only. When the FIFO is full, no read is issued, even if a pop occurs in the same cycle; one bubble is accepted.
- Simultaneous push and pop when not full leaves `count` unchanged and preserves FIFO order.
- Address arithmetic is 8-bit; 8'hFF increments to 8'h00 and fetching continues.
- `flush` (synchronous) clears `count` and the read/write pointers and forces IDLE, with no `done` pulse. `flush` wins over a simultaneous start.
- A rising edge of `acc_enable` while `busy` is high is ignored.
- Reset values: `instr_fetch_addr` 8'h00, `instr_rd_en` 0, `instr_out` 64'h0, `instr_valid` 0, `busy` 0, `done` 0, FIFO empty, state IDLE, `acc_enable` edge register 0.
- Asserting `rst` mid-run aborts immediately to the reset values. Data in flight is discarded.

## Timing
- `acc_enable` rise sampled at edge N → `busy` and `instr_rd_en` high from edge N, with `instr_fetch_addr = START_ADDR`.
- First word captured at edge N+1 → `instr_valid` high from edge N+1. Start-to-valid latency is 2 edges.
- Sustained throughput is one word per cycle while `instr_ready` stays high and the FIFO is not full.
- END captured at edge E → `instr_rd_en` low from edge E. Exactly one word past the previous one is read, and nothing after END.
- END popped at edge P → `done` high for the cycle after P; `busy` low from edge P.
- `instr_out` and `instr_valid` are driven from registers/FIFO storage only. There is no combinational path from `instr_port` or `instr_ready`.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds output ports `fetch_count` [15:0] (words read in the current run) and `stall_count` [15:0] (cycles with `instr_valid` high and `instr_ready` low).
  - Both counters clear on start and on reset, saturate at 16'hFFFF, and hold their values after `done`.
- `FETCH_PERF_CNT_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset then start: memory holds words 0..3 with opcodes 1, 2, 3, F; `instr_ready` tied 1 → words 0..3 emitted on consecutive cycles, `instr_valid` first high 2 edges after the `acc_enable` rise, `done` pulses once, exactly 4 reads issued.
- Backpressure: `instr_ready` 0 for 10 cycles with `FIFO_DEPTH` 4 and a 10-word program → exactly 4 reads, then `instr_rd_en` low. On release, all 10 words arrive in order with no loss or duplication; `stall_count` = 10 with the macro on.
- Wrap: `START_ADDR` 8'hFE, END at address 8'h01 → addresses FE, FF, 00, 01 read; `done` after the 4th pop.
- Flush mid-run at the 3rd cycle of FETCH → `busy` 0, `instr_valid` 0 the next cycle, no `done`. A new `acc_enable` rise restarts from `START_ADDR`.
- Retrigger: `acc_enable` toggled while `busy` → no restart, address sequence unbroken.
- Async reset asserted mid-DRAIN → all outputs at reset values without a clock edge; after release, IDLE.
